// File: rtl/sram_lsu_pkg.sv
// Shared types and byte-lane helpers for the SRAM load/store master.
package sram_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } lsu_state_e;

    // Wide enough for READ_LAT-1 with READ_LAT up to 4.
    localparam int LAT_CNT_W = 2;

    function automatic logic [3:0] store_mask(lsu_size_e size, logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << off;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(lsu_size_e size, logic [31:0] wdata);
        case (size)
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(lsu_size_e size, logic uns, logic [1:0] off,
                                                logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_B:    return {{24{~uns & sh[7]}}, sh[7:0]};
            SZ_H:    return {{16{~uns & sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/sram_lsu_master_if.sv
// Request/response channel between the MEM stage (master) and the LSU (slave).
interface sram_lsu_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/sram_lsu_lane_align.sv
// Combinational byte-lane steering for stores and lane extraction/extension for loads.
module sram_lsu_lane_align
    import sram_lsu_pkg::*;
(
    input  lsu_size_e   st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_wmask_o,
    output logic [31:0] st_wdata_o,
    input  lsu_size_e   ld_size_i,
    input  logic        ld_unsigned_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);
    assign st_wmask_o = store_mask(st_size_i, st_off_i);
    assign st_wdata_o = store_data(st_size_i, st_wdata_i);
    assign ld_data_o  = load_extend(ld_size_i, ld_unsigned_i, ld_off_i, ld_word_i);
endmodule

// File: rtl/sram_lsu_master.sv
// Single-outstanding load/store initiator for a single-port SRAM with READ_LAT read latency.
// Define LSU_RANGE_CHECK_EN to reject byte addresses beyond the SRAM instead of wrapping them.
module sram_lsu_master
    import sram_lsu_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int READ_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    sram_lsu_master_if.slave  lsu,
    output logic              csb_o,
    output logic              web_o,
    output logic [3:0]        wmask_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    input  logic [31:0]       rdata_i
);
    lsu_state_e           state_q;
    logic [LAT_CNT_W-1:0] lat_cnt_q;
    lsu_size_e            ld_size_q;
    logic                 ld_unsigned_q;
    logic [1:0]           ld_off_q;
    logic                 resp_valid_q;
    logic                 resp_err_q;
    logic [31:0]          resp_rdata_q;

    lsu_size_e   req_size;
    logic        misaligned;
    logic        range_err;
    logic        req_err;
    logic        accept;
    logic        sram_go;
    logic [3:0]  st_wmask;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign req_size = lsu_size_e'(lsu.req_size);

    // NOTE: default first so every path assigns the signal and no latch is inferred.
    always_comb begin
        misaligned = 1'b1;
        case (lsu.req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = lsu.req_addr[0];
            2'd2:    misaligned = |lsu.req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

`ifdef LSU_RANGE_CHECK_EN
    assign range_err = |lsu.req_addr[31:ADDR_W+2];
`else
    assign range_err = 1'b0;
`endif

    assign req_err = misaligned | range_err;
    // Reset gating keeps the SRAM pins idle while rst_ni is low, whatever the requester drives.
    assign accept  = rst_ni & (state_q == IDLE) & lsu.req_valid;
    assign sram_go = accept & ~req_err;

    sram_lsu_lane_align u_lane_align (
        .st_size_i     (req_size),
        .st_off_i      (lsu.req_addr[1:0]),
        .st_wdata_i    (lsu.req_wdata),
        .st_wmask_o    (st_wmask),
        .st_wdata_o    (st_wdata),
        .ld_size_i     (ld_size_q),
        .ld_unsigned_i (ld_unsigned_q),
        .ld_off_i      (ld_off_q),
        .ld_word_i     (rdata_i),
        .ld_data_o     (ld_data)
    );

    assign csb_o   = ~sram_go;
    assign web_o   = ~(sram_go & lsu.req_we);
    assign wmask_o = (sram_go & lsu.req_we) ? st_wmask : 4'b0000;
    assign wdata_o = (sram_go & lsu.req_we) ? st_wdata : 32'd0;
    assign addr_o  = sram_go ? lsu.req_addr[ADDR_W+1:2] : '0;

    assign lsu.req_ready  = (state_q == IDLE);
    assign lsu.resp_valid = resp_valid_q;
    assign lsu.resp_rdata = resp_rdata_q;
    assign lsu.resp_err   = resp_err_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            lat_cnt_q     <= '0;
            ld_size_q     <= SZ_B;
            ld_unsigned_q <= 1'b0;
            ld_off_q      <= 2'b00;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (sram_go && !lsu.req_we) begin
                            state_q       <= WAIT;
                            lat_cnt_q     <= LAT_CNT_W'(READ_LAT - 1);
                            ld_size_q     <= req_size;
                            ld_unsigned_q <= lsu.req_unsigned;
                            ld_off_q      <= lsu.req_addr[1:0];
                        end else begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= req_err;
                            resp_rdata_q <= 32'd0;
                        end
                    end
                end
                WAIT: begin
                    // rdata_i is valid on the edge READ_LAT cycles after the SRAM sampled the read.
                    if (lat_cnt_q == '0) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= ld_data;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - LAT_CNT_W'(1);
                    end
                end
                RESP: begin
                    if (lsu.resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_lsu_master.sv
// Self-checking bench for sram_lsu_master: directed vector table, reset-abort sequence, random traffic.
module tb_sram_lsu_master;
    localparam int ADDR_W   = 12;
    localparam int READ_LAT = 2;
    localparam int WORDS    = 1 << ADDR_W;
    localparam int BYTES    = WORDS * 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    sram_lsu_master_if lsu_if ();

    logic              csb_o;
    logic              web_o;
    logic [3:0]        wmask_o;
    logic [ADDR_W-1:0] addr_o;
    logic [31:0]       wdata_o;
    logic [31:0]       rdata_i;

    sram_lsu_master #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .lsu     (lsu_if),
        .csb_o   (csb_o),
        .web_o   (web_o),
        .wmask_o (wmask_o),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .rdata_i (rdata_i)
    );

    // Behavioural SRAM: masked writes, reads delivered READ_LAT edges after sampling, garbage otherwise.
    logic [31:0] sram    [WORDS];
    logic [31:0] rd_pipe [READ_LAT];
    int          csb_pulses = 0;
    assign rdata_i = rd_pipe[READ_LAT-1];

    always @(posedge clk_i) begin
        rd_pipe[0] <= 32'hDEAD_BEEF;
        if (!csb_o) begin
            csb_pulses <= csb_pulses + 1;
            if (!web_o) begin
                for (int l = 0; l < 4; l++) begin
                    if (wmask_o[l]) sram[addr_o][l*8 +: 8] <= wdata_o[l*8 +: 8];
                end
            end else begin
                rd_pipe[0] <= sram[addr_o];
            end
        end
        for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Reference model: a flat byte-addressed memory.
    logic [7:0] ref_mem [BYTES];
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic bit model_err(input logic [1:0] size, input logic [31:0] a);
        bit e;
        e = (size == 2'd3) || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0);
`ifdef LSU_RANGE_CHECK_EN
        if (a / BYTES != 0) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] a);
        int n;
        int base;
        logic [31:0] v;
        n    = 1 << size;
        base = int'(a % BYTES);
        v    = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[(base + k) % BYTES]) << (8 * k));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  lsu_if.req_ready,  1);
        check({tag, "_resp_valid"}, lsu_if.resp_valid, 0);
        check({tag, "_resp_rdata"}, lsu_if.resp_rdata, 0);
        check({tag, "_resp_err"},   lsu_if.resp_err,   0);
        check({tag, "_csb"},        csb_o,   1);
        check({tag, "_web"},        web_o,   1);
        check({tag, "_wmask"},      wmask_o, 0);
        check({tag, "_addr"},       addr_o,  0);
        check({tag, "_wdata"},      wdata_o, 0);
    endtask

    // One full transaction: accept-cycle pin checks, latency, stall stability, handshake turnaround.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input int hold,
                         output logic [31:0] got_rdata, output logic got_err);
        bit          err;
        int          n;
        int          base;
        int          pulses0;
        int          lat;
        logic [3:0]  emask;
        logic [31:0] ewd;
        logic [31:0] exp_rd;
        err    = model_err(size, addr);
        n      = 1 << size;
        base   = int'(addr % BYTES);
        exp_rd = (!err && !we) ? model_load(size, uns, addr) : 32'd0;

        @(negedge clk_i);
        lsu_if.req_valid    = 1'b1;
        lsu_if.req_we       = we;
        lsu_if.req_addr     = addr;
        lsu_if.req_wdata    = wdata;
        lsu_if.req_size     = size;
        lsu_if.req_unsigned = uns;
        #1;
        check("accept_ready", lsu_if.req_ready, 1);
        pulses0 = csb_pulses;
        if (err) begin
            check("err_csb", csb_o, 1);
            check("err_wmask", wmask_o, 0);
        end else begin
            check("csb", csb_o, 0);
            check("web", web_o, {31'd0, ~we});
            check("addr", addr_o, (addr / 4) % WORDS);
            if (we) begin
                emask = 4'b0000;
                for (int k = 0; k < n; k++) emask[(base % 4) + k] = 1'b1;
                for (int l = 0; l < 4; l++) ewd[8*l +: 8] = wdata[8*(l % n) +: 8];
                check("wmask", wmask_o, emask);
                check("wdata", wdata_o, ewd);
                for (int k = 0; k < n; k++) ref_mem[(base + k) % BYTES] = wdata[8*k +: 8];
            end
        end
        @(posedge clk_i);
        #1;
        lsu_if.req_valid = 1'b0;

        for (lat = 1; lat <= 20; lat++) begin
            @(negedge clk_i);
            if (lsu_if.resp_valid) break;
            check("busy_ready", lsu_if.req_ready, 0);
            check("busy_csb", csb_o, 1);
        end
        check("latency", lat, (we || err) ? 1 : 1 + READ_LAT);
        check("sram_accesses", csb_pulses - pulses0, err ? 0 : 1);
        got_rdata = lsu_if.resp_rdata;
        got_err   = lsu_if.resp_err;
        check("resp_rdata", got_rdata, exp_rd);
        check("resp_err", got_err, {31'd0, err});
        check("resp_ready_low", lsu_if.req_ready, 0);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk_i);
            check("stall_valid", lsu_if.resp_valid, 1);
            check("stall_rdata", lsu_if.resp_rdata, exp_rd);
            check("stall_err", lsu_if.resp_err, {31'd0, err});
            check("stall_ready", lsu_if.req_ready, 0);
        end

        lsu_if.resp_ready = 1'b1;
        @(posedge clk_i);
        #1;
        lsu_if.resp_ready = 1'b0;
        @(negedge clk_i);
        check("post_hs_ready", lsu_if.req_ready, 1);
        check("post_hs_valid", lsu_if.resp_valid, 0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    initial begin
        watchdog();
    end

    task automatic watchdog();
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] got_rd;
        logic        got_err;
        logic        r_we;
        logic [31:0] r_addr;
        logic [1:0]  r_size;

        for (int i = 0; i < WORDS; i++) begin
            w = i * 32'h9E37_79B1 + 32'h0BAD_F00D;
            sram[i] = w;
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
        end

        //          we    addr           wdata          sz    uns  hold exp_rdata      err
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h8001_1234, 2'd2, 1'b0, 0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0002, 32'h0,         2'd1, 1'b0, 0, 32'hFFFF_8001, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0002, 32'h0,         2'd1, 1'b1, 0, 32'h0000_8001, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0004, 32'h1122_3344, 2'd2, 1'b0, 0, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0006, 32'h1234_56AB, 2'd0, 1'b0, 0, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0004, 32'h0,         2'd2, 1'b0, 5, 32'h11AB_3344, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0006, 32'h0,         2'd0, 1'b0, 0, 32'hFFFF_FFAB, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0006, 32'h0,         2'd0, 1'b1, 0, 32'h0000_00AB, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0005, 32'h0,         2'd2, 1'b0, 0, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b0, 32'h0000_0001, 32'h0,         2'd1, 1'b0, 0, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 32'h0000_0008, 32'h0,         2'd3, 1'b0, 0, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b1, 32'h0000_000A, 32'h5555_BEEF, 2'd1, 1'b0, 0, 32'h0000_0000, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_000B, 32'h0,         2'd0, 1'b0, 0, 32'hFFFF_FFBE, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_000A, 32'h0,         2'd1, 1'b0, 2, 32'hFFFF_BEEF, 1'b0};
`ifdef LSU_RANGE_CHECK_EN
        vecs[14] = '{1'b1, 32'h0001_0000, 32'hCAFE_F00D, 2'd2, 1'b0, 0, 32'h0000_0000, 1'b1};
        vecs[15] = '{1'b0, 32'h0000_0000, 32'h0,         2'd2, 1'b0, 0, 32'h8001_1234, 1'b0};
`else
        vecs[14] = '{1'b1, 32'h0001_0000, 32'hCAFE_F00D, 2'd2, 1'b0, 0, 32'h0000_0000, 1'b0};
        vecs[15] = '{1'b0, 32'h0000_0000, 32'h0,         2'd2, 1'b0, 0, 32'hCAFE_F00D, 1'b0};
`endif

        lsu_if.req_valid    = 1'b0;
        lsu_if.req_we       = 1'b0;
        lsu_if.req_addr     = 32'd0;
        lsu_if.req_wdata    = 32'd0;
        lsu_if.req_size     = 2'd0;
        lsu_if.req_unsigned = 1'b0;
        lsu_if.resp_ready   = 1'b0;

        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("idle_csb", csb_o, 1);

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns,
                  vecs[i].hold, got_rd, got_err);
            check($sformatf("vec%0d_rdata", i), got_rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, got_err}, {31'd0, vecs[i].exp_err});
        end

        // Reset asserted while a load is waiting for SRAM data: the request is dropped silently.
        @(negedge clk_i);
        lsu_if.req_valid = 1'b1;
        lsu_if.req_we    = 1'b0;
        lsu_if.req_addr  = 32'h0000_0004;
        lsu_if.req_size  = 2'd2;
        @(posedge clk_i);
        #1;
        lsu_if.req_valid = 1'b0;
        @(negedge clk_i);
        check("wait_busy", lsu_if.req_ready, 0);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            check("abort_no_resp", lsu_if.resp_valid, 0);
            check("abort_ready", lsu_if.req_ready, 1);
        end

        for (int t = 0; t < 250; t++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 5) == 0) r_addr = r_addr | ($urandom << 14);
            issue(r_we, r_addr, $urandom, r_size, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), got_rd, got_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
